// File: rtl/tt_mask_pkg.sv
// Shared types for the LSU mask/index item channel arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tt_mask_pkg;

  // One mask/index item: mask bit above a 64-bit index or mask word.
  localparam int MASK_ITEM_W = 65;

  typedef struct packed {
    logic        mask;
    logic [63:0] idx;
  } mask_item_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/tt_mask_idx_fifo.sv
// Small synchronous FIFO holding one producer's pending mask/index entries.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: push while full is accepted only if a pop happens the same cycle.
//
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_push, i_push_dat        write an entry
//   i_pop                     remove the head entry (ignored when empty)
//   o_head_dat                current head entry
//   o_full, o_empty           occupancy flags
module tt_mask_idx_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 66
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign o_empty    = (count == '0);
  assign o_full     = (count == CW'(DEPTH));
  assign do_pop     = i_pop && !o_empty;
  // A simultaneous pop frees the slot, so a full FIFO still takes the push.
  assign do_push    = i_push && (!o_full || do_pop);
  assign o_head_dat = mem[rd_ptr];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= i_push_dat;
    end
  end

endmodule

// File: rtl/tt_mask_idx_arb.sv
// Credit-based arbiter sharing the LSU mask/index channel between NUM_REQ producers.
// Latency: 2 cycles from a push into an empty, granted FIFO to o_mask_idx_valid.
// Backpressure: items pop only while LSU credits remain; one producer credit returned per item.
//
// Build option TT_MASK_ARB_FIXED_PRIO_EN: when defined, idle arbitration is
// fixed priority (lowest index wins) and the round-robin pointer is removed.
//
// Ports:
//   i_clk, i_reset_n             clock, asynchronous active-low reset
//   i_req_valid/item/last        per-producer item push (last marks end of memop)
//   o_req_credit                 one-cycle credit pulse per forwarded item, per producer
//   o_mask_idx_valid/item/last_idx/src   registered item toward the LSU
//   i_mask_idx_credit            LSU returns one credit
//   o_err                        sticky: FIFO overflow or LSU credit overflow
module tt_mask_idx_arb
  import tt_mask_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int MASK_CREDITS = 2,
  parameter int ITEM_W       = MASK_ITEM_W
) (
  input  logic                               i_clk,
  input  logic                               i_reset_n,
  input  logic [NUM_REQ-1:0]                 i_req_valid,
  input  logic [NUM_REQ-1:0][ITEM_W-1:0]     i_req_item,
  input  logic [NUM_REQ-1:0]                 i_req_last,
  output logic [NUM_REQ-1:0]                 o_req_credit,
  output logic                               o_mask_idx_valid,
  output logic [ITEM_W-1:0]                  o_mask_idx_item,
  output logic                               o_mask_idx_last_idx,
  output logic [$clog2(NUM_REQ)-1:0]         o_mask_idx_src,
  input  logic                               i_mask_idx_credit,
  output logic                               o_err
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MASK_CREDITS + 1);
  localparam int ENT_W = ITEM_W + 1;

  logic [NUM_REQ-1:0][ENT_W-1:0] head;
  logic [NUM_REQ-1:0]            empty;
  logic [NUM_REQ-1:0]            full;
  logic [NUM_REQ-1:0]            pop_vec;
  logic [NUM_REQ-1:0]            drop;

  arb_state_e       state, state_nxt;
  logic [SRC_W-1:0] owner, owner_nxt;
  logic [SRC_W-1:0] scan_base;
  logic [SRC_W-1:0] pick;
  logic             found;
  int               cand;
  logic [SRC_W-1:0] win;
  logic             pop;

  logic [CNT_W-1:0] lsu_cnt;
  logic [CNT_W:0]   avail;
  logic             have_credit;
  logic             cnt_ovf;

  // Per-producer buffers; entry is {last, item}.
  for (genvar r = 0; r < NUM_REQ; r++) begin : g_fifo
    tt_mask_idx_fifo #(
      .DEPTH (MASK_CREDITS),
      .WIDTH (ENT_W)
    ) u_fifo (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_push     (i_req_valid[r]),
      .i_push_dat ({i_req_last[r], i_req_item[r]}),
      .i_pop      (pop_vec[r]),
      .o_head_dat (head[r]),
      .o_full     (full[r]),
      .o_empty    (empty[r])
    );
  end

  assign drop = i_req_valid & full & ~pop_vec;

  // A credit returned this cycle can be spent this cycle.
  assign avail       = {1'b0, lsu_cnt} + (CNT_W + 1)'(i_mask_idx_credit);
  assign have_credit = (avail != '0);
  assign cnt_ovf     = i_mask_idx_credit && (lsu_cnt == CNT_W'(MASK_CREDITS)) && !pop;

`ifdef TT_MASK_ARB_FIXED_PRIO_EN
  assign scan_base = '0;
`else
  logic [SRC_W-1:0] rr_ptr;

  // Pointer advances past the winner on every idle grant; locked pops leave it alone.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rr_ptr <= '0;
    end else if (state == ARB_IDLE && pop) begin
      rr_ptr <= (pick == SRC_W'(NUM_REQ - 1)) ? '0 : pick + SRC_W'(1);
    end
  end

  assign scan_base = rr_ptr;
`endif

  // First non-empty producer at or after scan_base, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(scan_base) + k) % NUM_REQ;
      if (!found && !empty[cand]) begin
        found = 1'b1;
        pick  = SRC_W'(cand);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    win       = owner;
    pop       = 1'b0;
    pop_vec   = '0;
    case (state)
      ARB_IDLE: begin
        if (found && have_credit) begin
          pop = 1'b1;
          win = pick;
          // A single-item memop never takes the lock.
          if (!head[pick][ENT_W-1]) begin
            state_nxt = ARB_LOCK;
            owner_nxt = pick;
          end
        end
      end
      ARB_LOCK: begin
        if (!empty[owner] && have_credit) begin
          pop = 1'b1;
          win = owner;
          if (head[owner][ENT_W-1]) begin
            state_nxt = ARB_IDLE;
          end
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
    if (pop) begin
      pop_vec[win] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= ARB_IDLE;
      owner   <= '0;
      lsu_cnt <= CNT_W'(MASK_CREDITS);
      o_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      // An unexpected extra LSU credit is flagged and not counted.
      if (!cnt_ovf) begin
        lsu_cnt <= CNT_W'(avail - (CNT_W + 1)'(pop));
      end
      if (cnt_ovf || (|drop)) begin
        o_err <= 1'b1;
      end
    end
  end

  // Output register: data holds between pops, valid and credit pulse for one cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_mask_idx_valid    <= 1'b0;
      o_mask_idx_item     <= '0;
      o_mask_idx_last_idx <= 1'b0;
      o_mask_idx_src      <= '0;
      o_req_credit        <= '0;
    end else begin
      o_mask_idx_valid <= pop;
      o_req_credit     <= pop_vec;
      if (pop) begin
        o_mask_idx_item     <= head[win][ITEM_W-1:0];
        o_mask_idx_last_idx <= head[win][ITEM_W];
        o_mask_idx_src      <= win;
      end
    end
  end

endmodule

// File: tb/tb_tt_mask_idx_arb.sv
module tb_tt_mask_idx_arb;
  import tt_mask_pkg::*;

  localparam int NR = 2;
  localparam int MC = 2;
  localparam int IW = MASK_ITEM_W;

  typedef logic [IW+1:0] ent_t;  // {src, last, item}
  typedef struct {
    int   c;
    ent_t e;
  } obs_t;

  logic                   i_clk = 1'b0;
  logic                   i_reset_n = 1'b1;
  logic [NR-1:0]          i_req_valid;
  logic [NR-1:0][IW-1:0]  i_req_item;
  logic [NR-1:0]          i_req_last;
  logic [NR-1:0]          o_req_credit;
  logic                   o_mask_idx_valid;
  logic [IW-1:0]          o_mask_idx_item;
  logic                   o_mask_idx_last_idx;
  logic [0:0]             o_mask_idx_src;
  logic                   i_mask_idx_credit;
  logic                   o_err;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  ent_t pend[NR][$];
  ent_t exp_q[$];
  obs_t obs_q[$];
  int   prod_cred[NR];
  int   cred_pulses[NR];
  logic lsu_auto;
  logic lsu_manual;

  tt_mask_idx_arb #(
    .NUM_REQ      (NR),
    .MASK_CREDITS (MC),
    .ITEM_W       (IW)
  ) dut (
    .i_clk               (i_clk),
    .i_reset_n           (i_reset_n),
    .i_req_valid         (i_req_valid),
    .i_req_item          (i_req_item),
    .i_req_last          (i_req_last),
    .o_req_credit        (o_req_credit),
    .o_mask_idx_valid    (o_mask_idx_valid),
    .o_mask_idx_item     (o_mask_idx_item),
    .o_mask_idx_last_idx (o_mask_idx_last_idx),
    .o_mask_idx_src      (o_mask_idx_src),
    .i_mask_idx_credit   (i_mask_idx_credit),
    .o_err               (o_err)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic logic [IW-1:0] mk_item();
    mask_item_t it;
    it.mask = 1'($urandom_range(0, 1));
    it.idx  = {$urandom, $urandom};
    return it;
  endfunction

  task automatic queue_burst(input int r, input int n);
    for (int i = 0; i < n; i++) pend[r].push_back({1'(r), (i == n - 1), mk_item()});
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      pend[r].delete();
      prod_cred[r]   = MC;
      cred_pulses[r] = 0;
    end
    exp_q.delete();
    obs_q.delete();
    lsu_auto   = 1'b1;
    lsu_manual = 1'b0;
  endtask

  // One cycle of the producer/LSU models: observe at negedge, then drive.
  task automatic tick();
    ent_t e;
    @(negedge i_clk);
    if (o_mask_idx_valid)
      obs_q.push_back('{cyc, {o_mask_idx_src, o_mask_idx_last_idx, o_mask_idx_item}});
    for (int r = 0; r < NR; r++) begin
      if (o_req_credit[r]) begin
        prod_cred[r]++;
        cred_pulses[r]++;
      end
    end
    for (int r = 0; r < NR; r++) begin
      i_req_valid[r] = 1'b0;
      if (pend[r].size() > 0 && prod_cred[r] > 0) begin
        e = pend[r].pop_front();
        i_req_valid[r] = 1'b1;
        i_req_item[r]  = e[IW-1:0];
        i_req_last[r]  = e[IW];
        prod_cred[r]--;
      end
    end
    i_mask_idx_credit = lsu_auto ? o_mask_idx_valid : lsu_manual;
  endtask

  task automatic apply_reset();
    @(negedge i_clk);
    i_reset_n         = 1'b0;
    i_req_valid       = '0;
    i_req_item        = '0;
    i_req_last        = '0;
    i_mask_idx_credit = 1'b0;
    model_reset();
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    i_req_valid       = '0;
    i_req_item        = '0;
    i_req_last        = '0;
    i_mask_idx_credit = 1'b0;
    model_reset();
    #1 i_reset_n = 1'b0;
    repeat (2) @(negedge i_clk);
    checks++; if (o_mask_idx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", o_mask_idx_valid); end
    checks++; if (o_mask_idx_item !== '0) begin errors++; $display("FAIL rst_item: got %h want 0", o_mask_idx_item); end
    checks++; if (o_mask_idx_last_idx !== 1'b0) begin errors++; $display("FAIL rst_last: got %b want 0", o_mask_idx_last_idx); end
    checks++; if (o_mask_idx_src !== 1'b0) begin errors++; $display("FAIL rst_src: got %b want 0", o_mask_idx_src); end
    checks++; if (o_req_credit !== 2'b00) begin errors++; $display("FAIL rst_credit: got %b want 00", o_req_credit); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", o_err); end
    @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  task automatic test_single_burst();
    int   t0;
    obs_t o;
    ent_t want;
    apply_reset();
    queue_burst(0, 4);
    for (int i = 0; i < 4; i++) exp_q.push_back(pend[0][i]);
    tick();
    t0 = cyc;
    repeat (20) tick();
    checks++;
    if (obs_q.size() == 0 || obs_q[0].c != t0 + 2) begin
      errors++; $display("FAIL t1_latency: first valid at cycle %0d want %0d", (obs_q.size() > 0) ? obs_q[0].c : -1, t0 + 2);
    end
    checks++;
    if (obs_q.size() < 4 || obs_q[3].c != obs_q[0].c + 3) begin
      errors++; $display("FAIL t1_throughput: %0d items, not back-to-back", obs_q.size());
    end
    checks++; if (cred_pulses[0] != 4) begin errors++; $display("FAIL t1_credits: got %0d pulses want 4", cred_pulses[0]); end
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL t1_item: got none want %h", want); end
      else begin
        o = obs_q.pop_front();
        if (o.e !== want) begin errors++; $display("FAIL t1_item: got %h want %h", o.e, want); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL t1_extra: got %0d extra items want 0", obs_q.size()); end
  endtask

  task automatic test_contention();
    obs_t o;
    ent_t want;
    apply_reset();
    queue_burst(0, 3);
    queue_burst(1, 3);
    queue_burst(0, 1);  // arrives while producer 0 is still being served
    for (int i = 0; i < 3; i++) exp_q.push_back(pend[0][i]);
    for (int i = 0; i < 3; i++) exp_q.push_back(pend[1][i]);
    exp_q.push_back(pend[0][3]);
    repeat (30) tick();
    checks++;
    if (obs_q.size() < 4 || obs_q[3].c != obs_q[2].c + 1) begin
      errors++; $display("FAIL t2_rearb_gap: idle cycle between last item and next grant");
    end
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL t2_item: got none want %h", want); end
      else begin
        o = obs_q.pop_front();
        if (o.e !== want) begin errors++; $display("FAIL t2_item: got %h want %h", o.e, want); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL t2_extra: got %0d extra items want 0", obs_q.size()); end
  endtask

  task automatic test_credit_stall();
    int   tk;
    obs_t o;
    ent_t want;
    apply_reset();
    lsu_auto = 1'b0;
    queue_burst(0, 3);
    for (int i = 0; i < 3; i++) exp_q.push_back(pend[0][i]);
    repeat (10) tick();
    checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL t3_stall: got %0d items want 2", obs_q.size()); end
    lsu_manual = 1'b1;
    tick();
    tk = cyc;
    lsu_manual = 1'b0;
    repeat (10) tick();
    checks++;
    if (obs_q.size() != 3 || obs_q[2].c != tk + 1) begin
      errors++; $display("FAIL t3_one_more: got %0d items, third at %0d want 3 items, third at %0d",
                         obs_q.size(), (obs_q.size() > 2) ? obs_q[2].c : -1, tk + 1);
    end
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL t3_item: got none want %h", want); end
      else begin
        o = obs_q.pop_front();
        if (o.e !== want) begin errors++; $display("FAIL t3_item: got %h want %h", o.e, want); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL t3_extra: got %0d extra items want 0", obs_q.size()); end
  endtask

  task automatic test_overflow();
    ent_t a0, a1, want;
    obs_t o;
    apply_reset();
    a0 = {1'b0, 1'b0, mk_item()};  // producer 0 takes the lock and starves producer 1
    a1 = {1'b0, 1'b1, mk_item()};
    pend[0].push_back(a0);
    queue_burst(1, 3);
    prod_cred[1] = 3;  // producer 1 deliberately overruns its credits
    exp_q.push_back(a0);
    exp_q.push_back(a1);
    exp_q.push_back(pend[1][0]);
    exp_q.push_back(pend[1][1]);
    repeat (3) tick();
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL t4_err_early: got %b want 0", o_err); end
    repeat (3) tick();
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL t4_err_set: got %b want 1", o_err); end
    pend[0].push_back(a1);
    repeat (20) tick();
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL t4_err_sticky: got %b want 1", o_err); end
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL t4_item: got none want %h", want); end
      else begin
        o = obs_q.pop_front();
        if (o.e !== want) begin errors++; $display("FAIL t4_item: got %h want %h", o.e, want); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL t4_extra: got %0d extra items want 0", obs_q.size()); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    ent_t want;
    apply_reset();
    lsu_auto = 1'b0;
    queue_burst(0, 3);
    exp_q.push_back(pend[0][0]);
    for (int i = 0; i < 10 && obs_q.size() == 0; i++) tick();
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL t5_first: got %0d items want 1 before reset", obs_q.size()); end
    i_reset_n = 1'b0;
    #1;
    checks++;
    if (o_mask_idx_valid !== 1'b0 || o_mask_idx_item !== '0 || o_mask_idx_src !== 1'b0 ||
        o_mask_idx_last_idx !== 1'b0 || o_req_credit !== 2'b00) begin
      errors++; $display("FAIL t5_async_rst: valid=%b src=%b last=%b credit=%b item=%h want all 0",
                         o_mask_idx_valid, o_mask_idx_src, o_mask_idx_last_idx, o_req_credit, o_mask_idx_item);
    end
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL t5_item: got none want %h", want); end
      else begin
        o = obs_q.pop_front();
        if (o.e !== want) begin errors++; $display("FAIL t5_item: got %h want %h", o.e, want); end
      end
    end
    i_req_valid       = '0;
    i_mask_idx_credit = 1'b0;
    model_reset();
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    lsu_auto  = 1'b0;
    queue_burst(1, 3);
    exp_q.push_back(pend[1][0]);
    exp_q.push_back(pend[1][1]);
    repeat (15) tick();
    checks++; if (cred_pulses[1] != 2) begin errors++; $display("FAIL t5_credits: got %0d pulses want 2", cred_pulses[1]); end
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL t5_item: got none want %h", want); end
      else begin
        o = obs_q.pop_front();
        if (o.e !== want) begin errors++; $display("FAIL t5_item: got %h want %h", o.e, want); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL t5_extra: got %0d extra items want 0", obs_q.size()); end
  endtask

  task automatic test_single_item_prio();
    obs_t o;
    ent_t want;
    apply_reset();
    queue_burst(0, 1);
    queue_burst(0, 1);
    queue_burst(1, 1);
    queue_burst(1, 1);
`ifdef TT_MASK_ARB_FIXED_PRIO_EN
    exp_q.push_back(pend[0][0]);
    exp_q.push_back(pend[0][1]);
    exp_q.push_back(pend[1][0]);
    exp_q.push_back(pend[1][1]);
`else
    exp_q.push_back(pend[0][0]);
    exp_q.push_back(pend[1][0]);
    exp_q.push_back(pend[0][1]);
    exp_q.push_back(pend[1][1]);
`endif
    repeat (15) tick();
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL t6_item: got none want %h", want); end
      else begin
        o = obs_q.pop_front();
        if (o.e !== want) begin errors++; $display("FAIL t6_item: got %h want %h", o.e, want); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL t6_extra: got %0d extra items want 0", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_contention();
    test_credit_stall();
    test_overflow();
    test_reset_mid();
    test_single_item_prio();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tt_mask_idx_arb.md
# tt_mask_idx_arb

Credit-based arbiter that shares the single LSU mask/index item channel between NUM_REQ mask/index producers, such as the memop mask sequencer and a second vector-memory issue slot. Each producer pushes 65-bit items into a private buffer inside the arbiter. The arbiter grants one producer at a time and holds the grant until that producer's last item of the memop has been sent. Items are forwarded only while LSU credits are available, and a credit is returned to the producer for every item forwarded.

## Interface
Parameters:
- NUM_REQ, 2, number of producers (2..4)
- MASK_CREDITS, 2, LSU-side credits; also the depth of each producer buffer
- ITEM_W, 65, item width ({mask bit, 64-bit index/mask word})

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_req_valid  in  NUM_REQ  producer r pushes an item this cycle
- i_req_item  in  NUM_REQ×ITEM_W  item per producer
- i_req_last  in  NUM_REQ  item is the last of the producer's memop
- o_req_credit  out  NUM_REQ  one-cycle credit return to producer r
- o_mask_idx_valid  out  1  item valid toward LSU
- o_mask_idx_item  out  ITEM_W  forwarded item
- o_mask_idx_last_idx  out  1  forwarded item is the last of the memop
- o_mask_idx_src  out  $clog2(NUM_REQ)  producer index of the forwarded item
- i_mask_idx_credit  in  1  LSU returns one credit
- o_err  out  1  sticky protocol error

## Operation
- Per-producer FIFO, depth MASK_CREDITS, entry width {last, item}.
  - A push while full is dropped and sets o_err.
  - Producers start with MASK_CREDITS credits and push only while holding a credit.
- LSU credit counter: width $clog2(MASK_CREDITS+1), reset value MASK_CREDITS.
  - avail = cnt + i_mask_idx_credit; next = avail − pop.
  - A pop requires avail > 0, so a credit returned in the same cycle is usable in that cycle.
  - A credit arriving while cnt == MASK_CREDITS and no pop occurs: counter holds, o_err is set.
- Arbitration state machine:
  - IDLE: if any FIFO is non-empty and avail > 0, select a winner round-robin starting at rr_ptr, then:
    - pop the winner's head;
    - rr_ptr ← winner+1 mod NUM_REQ;
    - if the popped entry has last = 0, go to LOCK with owner = winner; otherwise stay in IDLE.
    - If avail == 0, no selection is made and rr_ptr is unchanged.
  - LOCK: pop only from owner, whenever the owner's FIFO is non-empty and avail > 0. Popping an entry with last = 1 returns to IDLE. Other producers may keep filling their FIFOs but are not served.
- Pop side effects, all registered and visible in the cycle after the pop:
  - o_mask_idx_valid = 1;
  - o_mask_idx_item, o_mask_idx_last_idx and o_mask_idx_src taken from the popped entry;
  - o_req_credit[src] = 1.
  - In cycles with no pop, o_mask_idx_valid = 0 and the data outputs hold their previous value.
- Push and pop on the same FIFO in the same cycle are both performed; the pop reads the old head, and a full FIFO accepts the push.
- Reset, including mid-burst: FIFOs are emptied, the state returns to IDLE, rr_ptr = 0 and the credit counter = MASK_CREDITS. Producers must be reset with the block.

## Timing
- Reset values: o_mask_idx_valid 0, o_mask_idx_item 0, o_mask_idx_last_idx 0, o_mask_idx_src 0, o_req_credit 0, o_err 0.
- Latency from a push into an empty FIFO (producer granted, credits available) to o_mask_idx_valid: 2 cycles (push, pop, output register).
- Sustained throughput is one item per cycle while credits remain; the output is limited by the LSU credit round trip.
- Re-arbitration after a last item costs no idle cycle: the next grant can pop in the cycle after the last-item pop.
- o_err is cleared only by reset.

## Configuration
- TT_MASK_ARB_FIXED_PRIO_EN:
  - Defined: arbitration in IDLE is fixed priority, lowest index wins, and rr_ptr is removed.
  - Undefined (default): round-robin as described in Operation.
  - Locking, credits and timing are identical in both modes.

## Structure
- Shared package tt_mask_pkg:
  - arbitration state enum (IDLE, LOCK);
  - MASK_ITEM_W = 65;
  - the item struct {mask bit, idx[63:0]}.
- Sub-module tt_mask_idx_fifo: parameterised depth and width, synchronous push/pop, full/empty flags, asynchronous reset. Instantiated NUM_REQ times.

## Test plan
- Single producer, 4-item burst (last on item 4), LSU returns credits 1 cycle after each valid → 4 valids on src 0, last_idx only on the 4th, first valid 2 cycles after the first push, 4 o_req_credit[0] pulses.
- Both producers push 3-item bursts in the same cycle → all 3 of producer 0 are forwarded before any of producer 1 (rr_ptr = 0); next contention grants producer 1 first.
- LSU withholds credits after 2 items → valid stops after 2 items; one credit is returned → exactly 1 more item, in the same cycle the credit arrives plus the output-register cycle.
- Producer pushes a 3rd item with its FIFO full (MASK_CREDITS = 2, no pops) → item dropped, o_err = 1 and stays 1.
- Reset asserted mid-burst after 1 of 3 items → outputs reset immediately; after release, a new producer 1 burst is granted with 2 fresh credits.
- TT_MASK_ARB_FIXED_PRIO_EN defined, both producers repeatedly pushing single-item bursts → producer 0 always wins.
